gcd_initiator: RTL and testbench
================================

Name: gcd_initiator

Overview:
- Request-side front end for the Euclidean GCD core.
- Buffers operand pairs from a valid/ready producer.
- Launches each pair into the core through go/xin/yin and waits for the core's gld strobe.
- Captures the gcd value and returns it, tagged with its operands, over a valid/ready result interface.
- Short-circuits zero operands, which would never terminate in the core, and enforces a timeout.

Parameters:
- WIDTH, 4, operand/result bit width; matches the core's xin/yin/gcd width.
- DEPTH, 4, operand queue entries; power of two, >=2.
- TIMEOUT, 64, maximum cycles in WAIT before the request is aborted.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has an operand pair.
- in_ready  output  1  queue can accept; equals !full.
- in_x  input  WIDTH  operand x.
- in_y  input  WIDTH  operand y.
- go  output  1  start pulse to the GCD core.
- xin  output  WIDTH  x operand to the core.
- yin  output  WIDTH  y operand to the core.
- gld  input  1  core result-load strobe; serves as the done indication.
- gcd  input  WIDTH  core result; valid when gld=1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_gcd  output  WIDTH  result value.
- res_x  output  WIDTH  x operand of this result.
- res_y  output  WIDTH  y operand of this result.
- res_err  output  1  result aborted by timeout.
- busy  output  1  FSM not in IDLE, or queue non-empty.

Behaviour:
- Reset (clr=0 at a clk edge): queue emptied, FSM to IDLE, timeout counter 0. Outputs: go=0, xin=0, yin=0, res_valid=0, res_gcd=0, res_x=0, res_y=0, res_err=0, busy=0, in_ready=1.
- Reset mid-operation aborts silently: no result is produced, and a pending res_valid is dropped.
- Queue:
  - Circular FIFO with DEPTH entries.
  - Push when in_valid && in_ready.
  - Pop only on the RESULT handshake.
  - No bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
- FSM states are IDLE, CHECK, LAUNCH, WAIT, RESULT. All outputs are registered or Moore.
- IDLE: if the queue is non-empty -> CHECK.
- CHECK:
  - Loads the head pair into xin/yin and res_x/res_y.
  - If x==0 or y==0: res_gcd = x|y (gcd(0,0)=0), res_err=0 -> RESULT; go is never asserted.
  - Otherwise -> LAUNCH.
- LAUNCH:
  - go=1 for exactly this one cycle.
  - Timeout counter cleared -> WAIT.
- WAIT:
  - xin/yin held stable.
  - Counter increments each cycle.
  - If gld=1: res_gcd=gcd, res_err=0 -> RESULT.
  - Else if counter==TIMEOUT-1: res_gcd=0, res_err=1 -> RESULT.
  - If gld and timeout occur in the same cycle, gld wins.
- RESULT:
  - res_valid=1, with res_* held stable until res_ready=1.
  - On the handshake: pop the queue, res_valid=0 the following cycle -> IDLE.
- gld sampled outside WAIT is ignored.
- xin/yin keep their last values after a request completes.
- Latency:
  - Pair accepted at edge N: CHECK at N+1, go high during cycle N+2.
  - gld high in cycle M: res_valid high from cycle M+1.
  - Zero-operand pair: res_valid high 2 cycles after acceptance.
- Back-to-back requests: the next CHECK occurs no earlier than 1 cycle after the RESULT handshake. At most one request is outstanding at the core.
- Core convention: xin/yin are unsigned. WIDTH applies to all operand and result buses without extension.

Optional Feature:
- GCD_INIT_RECOVER_EN, when defined:
  - Adds output core_clr_n (1 bit, reset value 1).
  - On a timeout abort, core_clr_n is driven 0 for exactly 2 cycles, starting in the cycle RESULT is entered. This resynchronises a hung core.
  - The next LAUNCH is stalled until core_clr_n has returned to 1.
- When not defined: the port is absent and a timeout only reports res_err=1.

Test Plan:
- Push (12,8), core model answers gld with gcd=4 after 6 cycles -> go pulses once, 2 cycles after accept; res_valid with res_gcd=4, res_x=12, res_y=8, res_err=0.
- Push (0,9), then (0,0) -> go never asserted; results 9 and 0 in order, res_err=0.
- Push 5 pairs with res_ready=0 and DEPTH=4 -> in_ready=0 after 4 accepts; 5th pair accepted only after the first result handshake; results in FIFO order.
- Core model never asserts gld for (6,4) -> res_valid after TIMEOUT cycles in WAIT, res_gcd=0, res_err=1. With GCD_INIT_RECOVER_EN, core_clr_n is low for exactly 2 cycles.
- gld asserted in the same cycle the counter reaches TIMEOUT-1 with gcd=2 -> res_gcd=2, res_err=0.
- clr=0 during WAIT with 3 pairs queued -> next cycle go=0, res_valid=0, busy=0, in_ready=1; no stale result afterwards.

Source files
------------

// File: rtl/gcd_initiator_if.sv
// Operand, core and result signals of the GCD request front end.
// slave = the front end itself, master = producer/core/consumer side.
interface gcd_initiator_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             go;
    logic [WIDTH-1:0] xin;
    logic [WIDTH-1:0] yin;
    logic             gld;
    logic [WIDTH-1:0] gcd;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_gcd;
    logic [WIDTH-1:0] res_x;
    logic [WIDTH-1:0] res_y;
    logic             res_err;

    modport slave (
        input  in_valid, in_x, in_y, gld, gcd, res_ready,
        output in_ready, go, xin, yin, res_valid, res_gcd, res_x, res_y, res_err
    );

    modport master (
        output in_valid, in_x, in_y, gld, gcd, res_ready,
        input  in_ready, go, xin, yin, res_valid, res_gcd, res_x, res_y, res_err
    );
endinterface

// File: rtl/gcd_initiator.sv
// Queued request front end for the Euclidean GCD core with zero short-circuit and timeout.
// Optional GCD_INIT_RECOVER_EN adds core_clr_n, pulsed low for 2 cycles after a timeout.
module gcd_initiator #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               clr,
    gcd_initiator_if.slave     bus,
    output logic               busy
`ifdef GCD_INIT_RECOVER_EN
    , output logic             core_clr_n
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } pair_t;

    pair_t          mem [DEPTH];
    pair_t          head;
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count;
    logic [2:0]     state;
    logic [CW-1:0]  cnt;
    logic           push, pop, timeout_hit, launch_ok;

    assign head        = mem[rptr];
    assign bus.in_ready = (count != (AW+1)'(DEPTH));
    assign push        = bus.in_valid && bus.in_ready;
    assign pop         = (state == RESULT) && bus.res_ready;
    assign timeout_hit = (state == WAIT) && !bus.gld && (cnt == TMAX);

    assign bus.go        = (state == LAUNCH);
    assign bus.res_valid = (state == RESULT);
    assign busy          = (state != IDLE) || (count != '0);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{x: bus.in_x, y: bus.in_y};
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef GCD_INIT_RECOVER_EN
    logic [1:0] rcnt;

    // Low for the RESULT entry cycle and the one after; launches wait for release.
    always_ff @(posedge clk) begin
        if (!clr)
            rcnt <= '0;
        else if (timeout_hit)
            rcnt <= 2'd2;
        else if (rcnt != '0)
            rcnt <= rcnt - 1'b1;
    end

    assign core_clr_n = (rcnt == '0);
    assign launch_ok  = (rcnt == '0);
`else
    assign launch_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.xin     <= '0;
            bus.yin     <= '0;
            bus.res_gcd <= '0;
            bus.res_x   <= '0;
            bus.res_y   <= '0;
            bus.res_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0)
                        state <= CHECK;
                end
                CHECK: begin
                    bus.xin   <= head.x;
                    bus.yin   <= head.y;
                    bus.res_x <= head.x;
                    bus.res_y <= head.y;
                    // A zero operand would spin forever in the core; gcd(a,0)=a.
                    if (head.x == '0 || head.y == '0) begin
                        bus.res_gcd <= head.x | head.y;
                        bus.res_err <= 1'b0;
                        state       <= RESULT;
                    end else if (launch_ok) begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.gld) begin
                        bus.res_gcd <= bus.gcd;
                        bus.res_err <= 1'b0;
                        state       <= RESULT;
                    end else if (cnt == TMAX) begin
                        bus.res_gcd <= '0;
                        bus.res_err <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_initiator.sv
// Scoreboard bench for gcd_initiator with a behavioural GCD core model.
module tb_gcd_initiator;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic busy;
`ifdef GCD_INIT_RECOVER_EN
    logic core_clr_n;
`endif

    gcd_initiator_if #(.WIDTH(W)) bus ();

    gcd_initiator #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .clr  (clr),
        .bus  (bus),
        .busy (busy)
`ifdef GCD_INIT_RECOVER_EN
        , .core_clr_n (core_clr_n)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int x;
        int y;
        int e;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   go_cnt = 0;
    int   hs_cnt = 0;
    int   core_lat = 1;
    bit   core_hang = 1'b0;
    bit   core_busy = 1'b0;

    task automatic chk(string tag, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gcd_f(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core model: answers each go after core_lat cycles unless hung.
    initial begin
        int cx, cy;
        bus.gld = 1'b0;
        bus.gcd = '0;
        forever begin
            @(negedge clk);
            if (bus.go === 1'b1) begin
                go_cnt++;
                cx = int'(bus.xin);
                cy = int'(bus.yin);
                if (!core_hang) begin
                    core_busy = 1'b1;
                    repeat (core_lat) @(negedge clk);
                    bus.gld = 1'b1;
                    bus.gcd = W'(gcd_f(cx, cy));
                    @(negedge clk);
                    bus.gld = 1'b0;
                    bus.gcd = '0;
                    core_busy = 1'b0;
                end
            end
        end
    end

    // Result monitor: compares every handshake against the scoreboard head.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", int'(bus.res_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_gcd", int'(bus.res_gcd), e.g);
                    chk("res_x",   int'(bus.res_x),   e.x);
                    chk("res_y",   int'(bus.res_y),   e.y);
                    chk("res_err", int'(bus.res_err), e.e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic push(int x, int y, int err, output int hs_at);
        int n;
        bit acc;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_x = W'(x);
        bus.in_y = W'(y);
        do begin
            acc = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 300);
        bus.in_valid = 1'b0;
        chk("push_accept", int'(acc), 1);
        hs_at = hs_cnt;
        if (acc)
            sb.push_back('{err ? 0 : gcd_f(x, y), x, y, err});
    endtask

    task automatic run_one(int x, int y, int lat, bit hang, int err, int exp_n);
        int n, hs;
        core_lat  = lat;
        core_hang = hang;
        push(x, y, err, hs);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("go_c1", int'(bus.go), 0);
            if (n == 2) begin
                chk("go_c2", int'(bus.go), (x != 0 && y != 0) ? 1 : 0);
                if (x != 0 && y != 0) begin
                    chk("xin", int'(bus.xin), x);
                    chk("yin", int'(bus.yin), y);
                end
            end
            if (n == 3) chk("go_c3", int'(bus.go), 0);
        end
        chk("res_latency", n, exp_n);
`ifdef GCD_INIT_RECOVER_EN
        if (err != 0) begin
            chk("clrn_r0", int'(core_clr_n), 0);
            @(negedge clk);
            chk("clrn_r1", int'(core_clr_n), 0);
            @(negedge clk);
            chk("clrn_r2", int'(core_clr_n), 1);
        end
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || core_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", int'(n < 500), 1);
        @(negedge clk);
    endtask

    initial begin
        int g0, hs, hs0, hs5;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.res_ready = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_go",        int'(bus.go),        0);
        chk("rst_xin",       int'(bus.xin),       0);
        chk("rst_yin",       int'(bus.yin),       0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_gcd",   int'(bus.res_gcd),   0);
        chk("rst_res_x",     int'(bus.res_x),     0);
        chk("rst_res_y",     int'(bus.res_y),     0);
        chk("rst_res_err",   int'(bus.res_err),   0);
        chk("rst_busy",      int'(busy),          0);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
`ifdef GCD_INIT_RECOVER_EN
        chk("rst_core_clr_n", int'(core_clr_n), 1);
`endif
        clr = 1'b1;
        @(negedge clk);

        // Normal launch with 6-cycle core latency
        g0 = go_cnt;
        run_one(12, 8, 6, 1'b0, 0, 9);
        wait_idle();
        chk("go_once", go_cnt - g0, 1);

        // Zero operands never reach the core
        g0 = go_cnt;
        run_one(0, 9, 1, 1'b0, 0, 2);
        run_one(0, 0, 1, 1'b0, 0, 2);
        run_one(7, 0, 1, 1'b0, 0, 2);
        wait_idle();
        chk("zero_no_go", go_cnt - g0, 0);

        run_one(9, 6, 1, 1'b0, 0, 4);
        run_one(15, 15, 3, 1'b0, 0, 6);
        wait_idle();

        // Fill the queue while the consumer stalls
        bus.res_ready = 1'b0;
        core_lat  = 1;
        core_hang = 1'b0;
        hs0 = hs_cnt;
        push(8, 12, 0, hs);
        push(10, 4, 0, hs);
        push(9, 3, 0, hs);
        push(14, 7, 0, hs);
        chk("full_in_ready", int'(bus.in_ready), 0);
        chk("full_busy", int'(busy), 1);
        fork
            push(5, 10, 0, hs5);
            begin
                repeat (10) @(negedge clk);
                chk("stall_in_ready", int'(bus.in_ready), 0);
                chk("stall_res_valid", int'(bus.res_valid), 1);
                bus.res_ready = 1'b1;
            end
        join
        chk("fifth_after_hs", int'(hs5 > hs0), 1);
        wait_idle();
        chk("fill_results", hs_cnt - hs0, 5);

        // Hung core times out
        run_one(6, 4, 1, 1'b1, 1, 3 + TO);
        wait_idle();
        // gld on the last WAIT cycle wins over the timeout
        run_one(6, 4, TO, 1'b0, 0, 3 + TO);
        wait_idle();
        // gld one cycle too late is ignored
        run_one(6, 4, TO + 1, 1'b0, 1, 3 + TO);
        wait_idle();

        // Reset during WAIT with pairs still queued
        core_hang = 1'b1;
        push(6, 4, 1, hs);
        push(9, 3, 1, hs);
        push(5, 5, 1, hs);
        repeat (5) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("mid_rst_go",        int'(bus.go),        0);
        chk("mid_rst_res_valid", int'(bus.res_valid), 0);
        chk("mid_rst_busy",      int'(busy),          0);
        chk("mid_rst_in_ready",  int'(bus.in_ready),  1);
        clr = 1'b1;
        sb.delete();
        hs0 = hs_cnt;
        g0  = go_cnt;
        repeat (100) @(negedge clk);
        chk("no_stale_result", hs_cnt - hs0, 0);
        chk("no_stale_go", go_cnt - g0, 0);
        run_one(12, 8, 2, 1'b0, 0, 5);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
